// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared op codes, FSM encoding and requester-ID width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

  localparam int c_ID_W = 1;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_SHL = 3'b100;
  localparam logic [2:0] c_OP_SHR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Codes 110 and 111 are reserved.
  function automatic logic op_is_err(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ============================================================================
// Module      : alu_arbiter_alu
// Description : Purely combinational ALU: add, sub, and, or, logical shifts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_result
);

  localparam int c_SH_W = $clog2(WIDTH);

  // Any bit set above the shift-index field means the amount is >= WIDTH.
  logic w_shift_big;
  assign w_shift_big = (i_b >> c_SH_W) != '0;

  always_comb begin
    o_result = '0;
    case (i_op)
      c_OP_ADD: o_result = i_a + i_b;
      c_OP_SUB: o_result = i_a - i_b;
      c_OP_AND: o_result = i_a & i_b;
      c_OP_OR:  o_result = i_a | i_b;
      c_OP_SHL: o_result = w_shift_big ? '0 : (i_a << i_b[c_SH_W-1:0]);
      c_OP_SHR: o_result = w_shift_big ? '0 : (i_a >> i_b[c_SH_W-1:0]);
      default:  o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end sharing one ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_id,
  output logic             resp_err
);

  state_t              r_state;
  logic [c_ID_W-1:0]   r_last_grant;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [2:0]          r_op;
  logic [c_ID_W-1:0]   r_id;
  logic                r_resp_valid;
  logic [WIDTH-1:0]    r_resp_data;
  logic                r_resp_zero;
  logic                r_resp_err;
  logic [c_ID_W-1:0]   r_resp_id;

  logic                w_idle;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_err;
  logic [WIDTH-1:0]    w_alu_result;

  // On a tie the requester not granted last wins.
  assign w_idle   = (r_state == ST_IDLE) && !reset;
  assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant[0]);
  assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant[0]);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_err = op_is_err(r_op);

  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_zero  <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_a          <= w_grant1 ? req1_a  : req0_a;
            r_b          <= w_grant1 ? req1_b  : req0_b;
            r_op         <= w_grant1 ? req1_op : req0_op;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_resp_data  <= w_err ? '0 : w_alu_result;
          r_resp_zero  <= !w_err && (w_alu_result == '0);
          r_resp_err   <= w_err;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_zero  = r_resp_zero;
  assign resp_id    = r_resp_id;
  assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_zero, resp_id, resp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .resp_id    (resp_id),
    .resp_err   (resp_err)
  );

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for a grant, then for the response, then consumes it.
  // Returns at the negedge of the cycle after consumption (FSM back in IDLE).
  task automatic serve(input bit drop, output int gid, output int wt, output int lat,
                       output logic [31:0] d, output logic z, output logic id, output logic e);
    gid = -1; wt = 0; lat = -1; d = 'x; z = 1'bx; id = 1'bx; e = 1'bx;
    for (int i = 0; i < 10 && gid < 0; i++) begin
      #1;
      if (req0_ready) gid = 0;
      else if (req1_ready) gid = 1;
      else begin wt++; @(negedge clk); end
    end
    if (gid < 0) return;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(negedge clk);
      if (drop && i == 1) begin
        if (gid == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      end
      #1;
      if (resp_valid) lat = i;
    end
    if (lat < 0) return;
    d = resp_data; z = resp_zero; id = resp_id; e = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if ({resp_valid, resp_data, resp_zero, resp_id, resp_err} !== 36'd0) begin
      failures++;
      $display("FAIL reset_resp: got v=%b d=%h z=%b id=%b e=%b want all 0",
               resp_valid, resp_data, resp_zero, resp_id, resp_err);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int gid, wt, lat; logic [31:0] d; logic z, id, e;
    req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b000; req0_valid = 1'b1;
    serve(1'b1, gid, wt, lat, d, z, id, e);
    checks++;
    if (gid !== 0 || lat !== 2) begin
      failures++; $display("FAIL single_grant: got gid=%0d lat=%0d want gid=0 lat=2", gid, lat);
    end
    checks++;
    if (d !== 32'd8 || z !== 1'b0 || id !== 1'b0 || e !== 1'b0) begin
      failures++; $display("FAIL single_resp: got d=%h z=%b id=%b e=%b want 8 0 0 0", d, z, id, e);
    end
  endtask

  task automatic test_tie();
    int gid, wt, lat; logic [31:0] d; logic z, id, e;
    do_reset();
    req0_a = 32'd7;    req0_b = 32'd7;    req0_op = 3'b001;
    req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 3'b011;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(1'b1, gid, wt, lat, d, z, id, e);
    checks++;
    if (gid !== 0 || d !== 32'd0 || z !== 1'b1 || id !== 1'b0) begin
      failures++; $display("FAIL tie_first: got gid=%0d d=%h z=%b id=%b want 0 0 1 0", gid, d, z, id);
    end
    serve(1'b1, gid, wt, lat, d, z, id, e);
    checks++;
    if (gid !== 1 || wt !== 0 || lat !== 2) begin
      failures++; $display("FAIL tie_second_grant: got gid=%0d wait=%0d lat=%0d want 1 0 2", gid, wt, lat);
    end
    checks++;
    if (d !== 32'hFF || z !== 1'b0 || id !== 1'b1 || e !== 1'b0) begin
      failures++; $display("FAIL tie_second_resp: got d=%h z=%b id=%b e=%b want ff 0 1 0", d, z, id, e);
    end
  endtask

  task automatic test_backpressure();
    int gid, wt, lat; logic [31:0] d; logic z, id, e;
    bit seen;
    req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b000;
    req1_a = 32'd3;  req1_b = 32'd4;  req1_op = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (req0_ready) seen = 1; else @(negedge clk);
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_grant: got no req0_ready want req0_ready=1"); end
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'd30 || resp_id !== 1'b0 || resp_zero !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%b z=%b rdy=%b%b want 1 1e 0 0 00",
                 i, resp_valid, resp_data, resp_id, resp_zero, req0_ready, req1_ready);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got v=%b rdy=%b%b want v=0 rdy=01", resp_valid, req0_ready, req1_ready);
    end
    serve(1'b1, gid, wt, lat, d, z, id, e);
    req0_valid = 1'b0;
    checks++;
    if (gid !== 1 || d !== 32'd0 || z !== 1'b1 || id !== 1'b1) begin
      failures++; $display("FAIL bp_next: got gid=%0d d=%h z=%b id=%b want 1 0 1 1", gid, d, z, id);
    end
  endtask

  task automatic test_edge_ops();
    int gid, wt, lat; logic [31:0] d; logic z, id, e;
    logic [31:0] va [6] = '{32'hFFFFFFFF, 32'd1,  32'h80000000, 32'd1,  32'd0, 32'h1234};
    logic [31:0] vb [6] = '{32'd1,        32'd32, 32'd31,       32'd31, 32'd1, 32'h5678};
    logic [2:0]  vo [6] = '{3'b000,       3'b100, 3'b101,       3'b100, 3'b001, 3'b111};
    logic [31:0] xd [6] = '{32'd0,        32'd0,  32'd1,  32'h80000000, 32'hFFFFFFFF, 32'd0};
    logic        xz [6] = '{1'b1,         1'b1,   1'b0,         1'b0,   1'b0, 1'b0};
    logic        xe [6] = '{1'b0,         1'b0,   1'b0,         1'b0,   1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      req0_a = va[i]; req0_b = vb[i]; req0_op = vo[i]; req0_valid = 1'b1;
      serve(1'b1, gid, wt, lat, d, z, id, e);
      checks++;
      if (gid !== 0 || d !== xd[i] || z !== xz[i] || e !== xe[i]) begin
        failures++;
        $display("FAIL edge_op[%0d]: got gid=%0d d=%h z=%b e=%b want 0 %h %b %b",
                 i, gid, d, z, e, xd[i], xz[i], xe[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int gid, wt, lat; logic [31:0] d; logic z, id, e;
    req0_a = 32'd9; req0_b = 32'd9; req0_op = 3'b000; req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("FAIL mid_grant: got req0_ready=%b want 1", req0_ready);
    end
    @(negedge clk); req0_valid = 1'b0; reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b rdy=%b%b want 0 00", resp_valid, req0_ready, req1_ready);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL mid_replay: got resp_valid=%b want 0", resp_valid);
    end
    req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'b010;
    req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'b000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(1'b1, gid, wt, lat, d, z, id, e);
    checks++;
    if (gid !== 0 || d !== 32'd2 || id !== 1'b0) begin
      failures++; $display("FAIL mid_tie: got gid=%0d d=%h id=%b want 0 2 0", gid, d, id);
    end
    serve(1'b1, gid, wt, lat, d, z, id, e);
    checks++;
    if (gid !== 1 || d !== 32'd3 || id !== 1'b1) begin
      failures++; $display("FAIL mid_after: got gid=%0d d=%h id=%b want 1 3 1", gid, d, id);
    end
  endtask

  task automatic test_fairness();
    int gid, wt, lat; logic [31:0] d; logic z, id, e;
    do_reset();
    req0_a = 32'd100; req0_b = 32'd1; req0_op = 3'b001;
    req1_a = 32'd200; req1_b = 32'd1; req1_op = 3'b000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      serve(1'b0, gid, wt, lat, d, z, id, e);
      checks++;
      if (gid !== (i % 2) || id !== 1'(i % 2) || d !== ((i % 2) ? 32'd201 : 32'd99)) begin
        failures++;
        $display("FAIL fair[%0d]: got gid=%0d id=%b d=%h want %0d", i, gid, id, d, i % 2);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_op = '0; req1_op = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_edge_ops();
    test_reset_mid();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
